// File: rtl/fw_scoreboard.sv
// Forwarding and load-use hazard unit: tracks in-flight register writes
// below ID, picks the youngest producer per source and stalls on unready loads.
module fw_scoreboard #(
    parameter int  REG_W       = 4,
    parameter int  NUM_SRC     = 2,
    parameter int  DEPTH       = 2,
    parameter int  LOAD_STAGES = 1,
    parameter int  CNT_W       = 16,
    localparam int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_used,
    input  logic [REG_W-1:0]         id_dest,
    input  logic                     id_wr_en,
    input  logic                     id_is_load,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] ex_fw_sel,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Entry k holds the instruction k stages past ID (1 = EX).
    logic             ent_valid [1:DEPTH];
    logic [REG_W-1:0] ent_dest  [1:DEPTH];
    logic             ent_load  [1:DEPTH];

    logic [SEL_W-1:0] sel [NUM_SRC];
    logic             hazard;
    logic             advance;

    // Descending scan so the youngest matching producer overwrites older ones.
    always_comb begin
        hazard = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            sel[j] = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (id_valid && id_src_used[j] && ent_valid[k] &&
                    (ent_dest[k] == id_src[j*REG_W +: REG_W])) begin
                    sel[j] = SEL_W'(k);
                end
            end
            for (int k = 1; k <= LOAD_STAGES; k++) begin
                if ((sel[j] == SEL_W'(k)) && ent_load[k]) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // Handshake: id_valid is the valid, ~stall the ready; the ID instruction
    // moves into EX only on an edge with ~stall & ~flush, otherwise EX gets a bubble.
    assign stall   = hazard && !flush && !reset;
    assign advance = !stall && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                ent_valid[k] <= 1'b0;
                ent_dest[k]  <= '0;
                ent_load[k]  <= 1'b0;
            end
            ex_fw_sel <= '0;
            stall_cnt <= '0;
        end else begin
            if (advance) begin
                ent_valid[1] <= id_valid && id_wr_en;
                ent_dest[1]  <= id_dest;
                ent_load[1]  <= id_is_load;
            end else begin
                ent_valid[1] <= 1'b0;
                ent_dest[1]  <= '0;
                ent_load[1]  <= 1'b0;
            end

            // A flush squashes the instruction leaving EX as well.
            ent_valid[2] <= ent_valid[1] && !flush;
            ent_dest[2]  <= ent_dest[1];
            ent_load[2]  <= ent_load[1];

            for (int k = DEPTH; k >= 3; k--) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_dest[k]  <= ent_dest[k-1];
                ent_load[k]  <= ent_load[k-1];
            end

            for (int j = 0; j < NUM_SRC; j++) begin
                ex_fw_sel[j*SEL_W +: SEL_W] <= advance ? sel[j] : '0;
            end

            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fw_scoreboard.sv
// Bench for fw_scoreboard: directed hazard scenarios with literal expectations,
// then random traffic against a queue-based reference of the in-flight producers.
module tb_fw_scoreboard;

    localparam int REG_W       = 4;
    localparam int NUM_SRC     = 2;
    localparam int DEPTH       = 3;
    localparam int LOAD_STAGES = 1;
    localparam int CNT_W       = 4;
    localparam int SEL_W       = $clog2(DEPTH + 1);

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     id_valid;
    logic [NUM_SRC*REG_W-1:0] id_src;
    logic [NUM_SRC-1:0]       id_src_used;
    logic [REG_W-1:0]         id_dest;
    logic                     id_wr_en;
    logic                     id_is_load;
    logic                     flush;
    logic                     stall;
    logic [NUM_SRC*SEL_W-1:0] ex_fw_sel;
    logic [CNT_W-1:0]         stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fw_scoreboard #(
        .REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
        .LOAD_STAGES(LOAD_STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dest(id_dest), .id_wr_en(id_wr_en),
        .id_is_load(id_is_load), .flush(flush), .stall(stall),
        .ex_fw_sel(ex_fw_sel), .stall_cnt(stall_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_id(input bit v, input int s0, input int s1, input bit [1:0] used,
                          input int d, input bit wr, input bit ld, input bit fl);
        id_valid    = v;
        id_src      = {REG_W'(s1), REG_W'(s0)};
        id_src_used = used;
        id_dest     = REG_W'(d);
        id_wr_en    = wr;
        id_is_load  = ld;
        flush       = fl;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic int rnd_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 15 : r;
    endfunction

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] d;
        logic             ld;
    } ent_t;

    ent_t                     hist [$];   // hist[0] = instruction in EX
    logic [NUM_SRC*SEL_W-1:0] m_fw;
    int                       m_cnt;
    bit                       known = 0;
    logic [NUM_SRC*SEL_W-1:0] exp_q [$];  // registered bypass selects, oldest first

    always @(negedge clk) begin : cmp
        int   s [NUM_SRC];
        bit   st;
        bit   adv;
        bit   found;
        ent_t ne;
        logic [REG_W-1:0] src;

        if (known) begin
            check("fw_sel", ex_fw_sel, m_fw);
            check("stall_cnt", stall_cnt, m_cnt);
        end

        st = 0;
        for (int j = 0; j < NUM_SRC; j++) begin
            s[j]  = 0;
            found = 0;
            src   = id_src[j*REG_W +: REG_W];
            if (id_valid && id_src_used[j]) begin
                for (int i = 0; i < hist.size(); i++) begin
                    if (!found && hist[i].v && hist[i].d == src) begin
                        s[j]  = i + 1;
                        found = 1;
                    end
                end
            end
            if (s[j] != 0 && s[j] <= LOAD_STAGES && hist[s[j]-1].ld) st = 1;
        end
        if (reset || flush) st = 0;

        if (known || reset) check("stall", stall, st);

        if (reset) begin
            hist.delete();
            for (int k = 0; k < DEPTH; k++) hist.push_back('0);
            m_fw  = '0;
            m_cnt = 0;
            exp_q.delete();
            known = 1;
        end else if (known) begin
            adv = !st && !flush;
            ne  = adv ? ent_t'{v: id_valid && id_wr_en, d: id_dest, ld: id_is_load} : ent_t'('0);
            if (flush) hist[0].v = 1'b0;
            hist.push_front(ne);
            void'(hist.pop_back());
            for (int j = 0; j < NUM_SRC; j++) begin
                m_fw[j*SEL_W +: SEL_W] = adv ? SEL_W'(s[j]) : '0;
            end
            exp_q.push_back(m_fw);
            if (exp_q.size() > 4) void'(exp_q.pop_front());
            if (st && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        nop();

        // Reset state
        tick();
        settle();
        check("rst_stall", stall, 0);
        check("rst_fw", ex_fw_sel, 0);
        check("rst_cnt", stall_cnt, 0);
        tick();
        reset = 1'b0;

        // Back-to-back ALU: ADD r3 then SUB r6,r3,r4
        set_id(1, 0, 0, 2'b00, 3, 1, 0, 0);
        tick();
        set_id(1, 3, 4, 2'b11, 6, 1, 0, 0);
        settle();
        check("alu_stall", stall, 0);
        tick();
        nop();
        settle();
        check("alu_fw", ex_fw_sel, 4'b0001);
        tick();

        // Load-use: LDR r5 then ADD r1,r5,r5
        set_id(1, 0, 0, 2'b00, 5, 1, 1, 0);
        tick();
        set_id(1, 5, 5, 2'b11, 1, 1, 0, 0);
        settle();
        check("lu_stall", stall, 1);
        tick();
        settle();
        check("lu_stall_after", stall, 0);
        check("lu_cnt", stall_cnt, 1);
        check("lu_bubble", ex_fw_sel, 0);
        tick();
        nop();
        settle();
        check("lu_fw", ex_fw_sel, 4'b1010);
        tick();

        // Youngest wins: LDR r2, ADD r2, use r2
        set_id(1, 0, 0, 2'b00, 2, 1, 1, 0);
        tick();
        set_id(1, 0, 0, 2'b00, 2, 1, 0, 0);
        tick();
        set_id(1, 2, 2, 2'b11, 7, 1, 0, 0);
        settle();
        check("yw_stall", stall, 0);
        tick();
        nop();
        settle();
        check("yw_fw", ex_fw_sel, 4'b0101);
        tick();

        // Swapped: ADD r2, LDR r2, use r2
        set_id(1, 0, 0, 2'b00, 2, 1, 0, 0);
        tick();
        set_id(1, 0, 0, 2'b00, 2, 1, 1, 0);
        tick();
        set_id(1, 2, 2, 2'b11, 7, 1, 0, 0);
        settle();
        check("sw_stall", stall, 1);
        tick();
        settle();
        check("sw_stall_after", stall, 0);
        check("sw_cnt", stall_cnt, 2);
        tick();
        nop();
        settle();
        check("sw_fw", ex_fw_sel, 4'b1010);
        tick();

        // Unused source, invalid ID, non-writing producer
        set_id(1, 0, 0, 2'b00, 8, 1, 1, 0);
        tick();
        set_id(1, 8, 8, 2'b00, 7, 1, 0, 0);
        settle();
        check("unused_stall", stall, 0);
        tick();
        nop();
        settle();
        check("unused_fw", ex_fw_sel, 0);
        tick();
        set_id(1, 0, 0, 2'b00, 9, 1, 1, 0);
        tick();
        set_id(0, 9, 9, 2'b11, 7, 1, 0, 0);
        settle();
        check("invalid_stall", stall, 0);
        tick();
        nop();
        settle();
        check("invalid_fw", ex_fw_sel, 0);
        tick();
        set_id(1, 0, 0, 2'b00, 10, 0, 1, 0);
        tick();
        set_id(1, 10, 10, 2'b11, 7, 1, 0, 0);
        settle();
        check("nowr_stall", stall, 0);
        tick();
        nop();
        settle();
        check("nowr_fw", ex_fw_sel, 0);
        tick();

        // Flush with a pending load-use
        set_id(1, 0, 0, 2'b00, 4, 1, 1, 0);
        tick();
        set_id(1, 4, 0, 2'b01, 7, 1, 0, 1);
        settle();
        check("flush_stall", stall, 0);
        tick();
        set_id(1, 4, 4, 2'b11, 7, 1, 0, 0);
        settle();
        check("flush_cnt", stall_cnt, 2);
        check("flush_bubble", ex_fw_sel, 0);
        check("flush_nohaz", stall, 0);
        tick();
        nop();
        settle();
        check("flush_sel", ex_fw_sel, 0);
        tick();

        // Saturation: 20 load-use stalls with a 4-bit counter
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_id(1, 0, 0, 2'b00, 5, 1, 1, 0);
            tick();
            set_id(1, 5, 0, 2'b01, 1, 1, 0, 0);
            tick();
            tick();
            if (i == 9) begin
                settle();
                check("cnt_mid", stall_cnt, 10);
            end
        end
        nop();
        settle();
        check("cnt_sat", stall_cnt, 15);
        tick();

        // Reset in the middle of a stall
        set_id(1, 0, 0, 2'b00, 5, 1, 1, 0);
        tick();
        set_id(1, 5, 5, 2'b11, 1, 1, 0, 0);
        settle();
        check("rms_stall", stall, 1);
        reset = 1'b1;
        #1;
        check("rms_comb", stall, 0);
        tick();
        reset = 1'b0;
        settle();
        check("rms_cnt", stall_cnt, 0);
        check("rms_fw", ex_fw_sel, 0);
        check("rms_nohaz", stall, 0);
        tick();
        nop();
        settle();
        check("rms_sel", ex_fw_sel, 0);
        tick();

        // Random traffic checked by the reference model every cycle
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) < 2);
            set_id($urandom_range(0, 9) != 0, rnd_reg(), rnd_reg(),
                   2'($urandom_range(0, 3)), rnd_reg(),
                   $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
                   $urandom_range(0, 99) < 8);
            tick();
        end
        reset = 1'b0;
        nop();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
